// File: rtl/ntt_dispatch_ctrl_if.sv
// Host-side bundle of the NTT dispatcher: load beats in, read requests in,
// readback words out.
interface ntt_dispatch_ctrl_if #(
    parameter int NUM_PROC = 4,
    parameter int DATA_W   = 32
);
    localparam int PW = $clog2(NUM_PROC);

    logic [DATA_W-1:0] s_din;
    logic [PW-1:0]     s_proc_num;
    logic              s_din_valid;
    logic              s_din_ready;

    logic [PW-1:0]     m_proc_num;
    logic              m_proc_num_valid;
    logic              m_proc_num_ready;

    logic [DATA_W-1:0] m_dout;
    logic              m_dout_valid;
    logic              m_dout_ready;

    // master is the stream shell, slave is the dispatcher
    modport master (
        output s_din, s_proc_num, s_din_valid,
        input  s_din_ready,
        output m_proc_num, m_proc_num_valid,
        input  m_proc_num_ready,
        input  m_dout, m_dout_valid,
        output m_dout_ready
    );

    modport slave (
        input  s_din, s_proc_num, s_din_valid,
        output s_din_ready,
        input  m_proc_num, m_proc_num_valid,
        output m_proc_num_ready,
        output m_dout, m_dout_valid,
        input  m_dout_ready
    );
endinterface

// File: rtl/ntt_dispatch_ctrl.sv
// Host-side dispatcher for the NTT processor array: load routing with per-processor
// word counting, credit-limited readback into a show-ahead FIFO, run start/finish.
module ntt_dispatch_ctrl #(
    parameter int NUM_PROC       = 4,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_PROC = 256,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    output logic                       finish_o,
    output logic                       busy_o,
    ntt_dispatch_ctrl_if.slave         host,
    output logic                       proc_start_o,
    input  logic [NUM_PROC-1:0]        proc_finish_i,
    output logic [DATA_W-1:0]          proc_din_o,
    output logic [NUM_PROC-1:0]        proc_din_valid_o,
    output logic [NUM_PROC-1:0]        proc_read_valid_o,
    input  logic [NUM_PROC*DATA_W-1:0] proc_dout_i,
    input  logic [NUM_PROC-1:0]        proc_dout_valid_i,
    output logic [NUM_PROC-1:0]        loaded_o,
    output logic [1:0]                 err_o
);
    localparam int PW = $clog2(NUM_PROC);
    localparam int CW = $clog2(WORDS_PER_PROC) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam bit PROC_POW2 = (NUM_PROC == (1 << PW));
    localparam logic [NUM_PROC-1:0] PROC_LSB = {{(NUM_PROC-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 start_q;
    logic                 startEdge;
    logic                 startAccept;
    logic                 procStart_q;
    logic                 finish_q, finish_d;

    logic                 loadAccept;
    logic                 loadInRange;
    logic                 loadHit;
    logic [CW-1:0]        cnt_q [NUM_PROC];
    logic [CW-1:0]        cntNext;
    logic [NUM_PROC-1:0]  loaded_q;
    logic [DATA_W-1:0]    procDin_q;
    logic [NUM_PROC-1:0]  procDinValid_q;

    logic                 readReady;
    logic                 reqAccept;
    logic [FW:0]          creditUsed;
    logic [FW-1:0]        outst_q;
    logic [NUM_PROC-1:0]  procReadValid_q;

    logic [PW-1:0]        retIdx;
    logic                 retFound;
    logic                 retMulti;
    logic                 retPush;
    logic                 retErr;
    logic [DATA_W-1:0]    retData;

    logic [DATA_W-1:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr_q, rdPtr_q;
    logic [FW-1:0]        fifoCount_q;
    logic                 fifoPop;

    logic [1:0]           err_q;

    assign startEdge = start_i & ~start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            procStart_q <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_i;
            procStart_q <= startAccept;
            finish_q    <= finish_d;
        end
    end

    // Completion is ignored during the start pulse so a stale finish level cannot end a fresh run
    always_comb begin
        state_d     = state_q;
        finish_d    = finish_q;
        startAccept = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (startEdge) begin
                    state_d     = RUN;
                    finish_d    = 1'b0;
                    startAccept = 1'b1;
                end
            end
            RUN: begin
                if ((&proc_finish_i) && !procStart_q) begin
                    state_d  = DONE;
                    finish_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign loadAccept  = host.s_din_valid && host.s_din_ready;
    assign loadInRange = PROC_POW2 || (int'(host.s_proc_num) < NUM_PROC);
    assign loadHit     = loadAccept && loadInRange;
    assign cntNext     = cnt_q[host.s_proc_num] + CW'(1);

    // An accepted start wins over a beat counted in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            procDin_q      <= '0;
            procDinValid_q <= '0;
            loaded_q       <= '0;
            for (int i = 0; i < NUM_PROC; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            procDinValid_q <= '0;
            if (loadAccept) begin
                procDin_q <= host.s_din;
            end
            if (loadHit) begin
                procDinValid_q <= PROC_LSB << host.s_proc_num;
            end
            if (startAccept) begin
                loaded_q <= '0;
                for (int i = 0; i < NUM_PROC; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (loadHit) begin
                if (cntNext == CW'(WORDS_PER_PROC)) begin
                    cnt_q[host.s_proc_num]    <= '0;
                    loaded_q[host.s_proc_num] <= 1'b1;
                end else begin
                    cnt_q[host.s_proc_num] <= cntNext;
                end
            end
        end
    end

    assign creditUsed = {1'b0, fifoCount_q} + {1'b0, outst_q};
    assign readReady  = (state_q != RUN) && (creditUsed < (FW+1)'(FIFO_DEPTH));
    assign reqAccept  = host.m_proc_num_valid && readReady;

    always_comb begin
        retIdx   = '0;
        retFound = 1'b0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (proc_dout_valid_i[i] && !retFound) begin
                retIdx   = PW'(i);
                retFound = 1'b1;
            end
        end
    end

    assign retMulti = |(proc_dout_valid_i & (proc_dout_valid_i - PROC_LSB));
    assign retPush  = retFound && (outst_q != '0);
    assign retErr   = retMulti || (retFound && (outst_q == '0));
    assign retData  = proc_dout_i[int'(retIdx)*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            procReadValid_q <= '0;
            outst_q         <= '0;
        end else begin
            procReadValid_q <= reqAccept ? (PROC_LSB << host.m_proc_num) : '0;
            if (reqAccept && !retPush) begin
                outst_q <= outst_q + FW'(1);
            end else if (!reqAccept && retPush) begin
                outst_q <= outst_q - FW'(1);
            end
        end
    end

    // Credits cover every push, so the FIFO needs no full check
    assign fifoPop = host.m_dout_ready && (fifoCount_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoMem_q[i] <= '0;
            end
        end else begin
            if (retPush) begin
                fifoMem_q[wrPtr_q] <= retData;
                wrPtr_q            <= wrPtr_q + AW'(1);
            end
            if (fifoPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({retPush, fifoPop})
                2'b10:   fifoCount_q <= fifoCount_q + FW'(1);
                2'b01:   fifoCount_q <= fifoCount_q - FW'(1);
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (loadAccept && !loadInRange) begin
                err_q[0] <= 1'b1;
            end
            if (retErr) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign host.s_din_ready      = (state_q != RUN);
    assign host.m_proc_num_ready = readReady;
    assign host.m_dout           = fifoMem_q[rdPtr_q];
    assign host.m_dout_valid     = (fifoCount_q != '0);

    assign finish_o          = finish_q;
    assign busy_o            = (state_q == RUN);
    assign proc_start_o      = procStart_q;
    assign proc_din_o        = procDin_q;
    assign proc_din_valid_o  = procDinValid_q;
    assign proc_read_valid_o = procReadValid_q;
    assign loaded_o          = loaded_q;
    assign err_o             = err_q;
endmodule
